// File: rtl/paro_pkg.sv
// Shared types and helpers for the stop ramp: state encoding, brake length and
// selection of the starting stage from the start FSM outputs.
package paro_pkg;

  typedef enum logic [2:0] {IDLE, S100, S50, S30, OFF} state_t;

  localparam int FRENO_TICKS = 2;

  function automatic state_t start_stage(input logic in_30, input logic in_50,
                                         input logic in_100);
    if (in_100)     return S100;
    else if (in_50) return S50;
    else if (in_30) return S30;
    else            return OFF;
  endfunction

endpackage

// File: rtl/tick_gen_en.sv
// Free-running divider producing a one-clock enable every CLK_DIV clocks,
// used instead of a derived clock.
module tick_gen_en #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/paro_rampa_parcial.sv
// Motor stop ramp: steps a running motor from 100/50/30 % down to off on timed
// holds. Optional brake output freno when PARO_FRENO_EN is defined.
module paro_rampa_parcial
  import paro_pkg::*;
#(
  parameter int CLK_DIV  = 50_000_000,
  parameter int HOLD_100 = 3,
  parameter int HOLD_50  = 3,
  parameter int HOLD_30  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic Parar,
  input  logic Emergencia,
  input  logic in_30,
  input  logic in_50,
  input  logic in_100,
  output logic out_30,
  output logic out_50,
  output logic out_100,
  output logic busy,
  output logic done
`ifdef PARO_FRENO_EN
  ,
  output logic freno
`endif
);

  localparam int H100 = (HOLD_100 < 1) ? 1 : HOLD_100;
  localparam int H50  = (HOLD_50  < 1) ? 1 : HOLD_50;
  localparam int H30  = (HOLD_30  < 1) ? 1 : HOLD_30;
  localparam int HMAX_RAMP = (H100 > H50) ? ((H100 > H30) ? H100 : H30)
                                          : ((H50  > H30) ? H50  : H30);
`ifdef PARO_FRENO_EN
  localparam int HMAX = (HMAX_RAMP > FRENO_TICKS) ? HMAX_RAMP : FRENO_TICKS;
`else
  localparam int HMAX = HMAX_RAMP;
`endif
  localparam int HC_W = $clog2(HMAX) + 1;
  localparam logic [HC_W-1:0] LAST_100 = HC_W'(H100 - 1);
  localparam logic [HC_W-1:0] LAST_50  = HC_W'(H50 - 1);
  localparam logic [HC_W-1:0] LAST_30  = HC_W'(H30 - 1);

  logic            tick;
  state_t          state, state_nxt;
  logic [HC_W-1:0] hold_cnt;
  logic            emer_lat;
  logic            parar_blk;
  logic            hold_clr;

  tick_gen_en #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (reset_n),
    .tick  (tick)
  );

`ifdef PARO_FRENO_EN
  localparam logic [HC_W-1:0] FRENO_LAST = HC_W'(FRENO_TICKS - 1);

  // Emergencia in IDLE holds the count at zero so the brake window restarts.
  assign parar_blk = freno;
  assign hold_clr  = (state_nxt != state) || (state == IDLE && Emergencia);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      freno <= 1'b0;
    else if (state_nxt == OFF)
      freno <= 1'b1;
    else if (state == IDLE && !Emergencia && tick && hold_cnt == FRENO_LAST)
      freno <= 1'b0;
  end
`else
  assign parar_blk = 1'b0;
  assign hold_clr  = (state_nxt != state);
`endif

  // emer_lat remembers an emergency already serviced so a held Emergencia
  // does not keep pulsing done from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Emergencia) begin
          if (!emer_lat) state_nxt = OFF;
        end else if (Parar && !parar_blk) begin
          state_nxt = start_stage(in_30, in_50, in_100);
        end
      end
      S100: begin
        if (Emergencia)                       state_nxt = OFF;
        else if (tick && hold_cnt == LAST_100) state_nxt = S50;
      end
      S50: begin
        if (Emergencia)                      state_nxt = OFF;
        else if (tick && hold_cnt == LAST_50) state_nxt = S30;
      end
      S30: begin
        if (Emergencia)                      state_nxt = OFF;
        else if (tick && hold_cnt == LAST_30) state_nxt = OFF;
      end
      OFF:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      emer_lat <= 1'b0;
    end else begin
      state    <= state_nxt;
      emer_lat <= Emergencia && (emer_lat || state == OFF);
      if (hold_clr)
        hold_cnt <= '0;
      else if (tick && hold_cnt != '1)
        hold_cnt <= hold_cnt + HC_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_100 <= 1'b0;
      out_50  <= 1'b0;
      out_30  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      out_100 <= (state_nxt == S100);
      out_50  <= (state_nxt == S50);
      out_30  <= (state_nxt == S30);
      busy    <= (state_nxt == S100) || (state_nxt == S50) || (state_nxt == S30);
      done    <= (state_nxt == OFF);
    end
  end

endmodule
